// File: rtl/apple1_io_pkg.sv
// Shared definitions for the Apple-1 PIA replacement: register offsets,
// character constants and the host keystroke translation.
package apple1_io_pkg;

  typedef enum logic [1:0] {
    REG_KBD   = 2'd0,
    REG_KBDCR = 2'd1,
    REG_DSP   = 2'd2,
    REG_DSPCR = 2'd3
  } reg_off_e;

  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;

  // The Apple-1 monitor expects CR line endings and upper-case letters only.
  function automatic logic [6:0] translate_key(input logic [7:0] c,
                                               input logic       lf_to_cr,
                                               input logic       upcase);
    if (lf_to_cr && c == CHAR_LF)
      return CHAR_CR[6:0];
    else if (upcase && c >= 8'h61 && c <= 8'h7A)
      return c[6:0] - 7'h20;
    else
      return c[6:0];
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with occupancy count; a pop frees a slot for a push in
// the same cycle, but an empty FIFO cannot bypass a push straight to pop.
module io_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, regardless of block order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count makes stale entries
  // unreachable, and leaving it unreset lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/apple1_pia_io.sv
// Apple-1 style PIA window (KBD/KBDCR/DSP/DSPCR) bridging the CPU bus to
// buffered host keyboard and display character streams.
module apple1_pia_io
  import apple1_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hD010,
  parameter int          KBD_DEPTH = 16,
  parameter int          DSP_DEPTH = 16,
  parameter int          LF_TO_CR  = 1,
  parameter int          UPCASE    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_rdata,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  output logic [6:0]  dsp_data,
  output logic        dsp_valid,
  input  logic        dsp_ready,
  output logic        dsp_overflow
);

  localparam int KAW = $clog2(KBD_DEPTH);
  localparam int DAW = $clog2(DSP_DEPTH);

  logic       sel, rd_en, wr_en;
  reg_off_e   reg_off;
  logic       kbd_push, kbd_pop, kbd_full, kbd_empty;
  logic       dsp_push, dsp_pop, dsp_full, dsp_empty, dsp_drop;
  logic [6:0] kbd_head;
  logic [KAW:0] kbd_count;
  logic [DAW:0] dsp_count;
  logic       unused_counts;

  logic [7:0] rdata_d, rdata_q;
  logic [6:0] last_key_q;
  logic [7:0] dspcr_q;
  logic       overflow_q;

  assign sel     = (cpu_addr[15:2] == BASE_ADDR[15:2]);
  assign rd_en   = sel && cpu_rd && !cpu_wr;
  assign wr_en   = sel && cpu_wr;
  assign reg_off = reg_off_e'(cpu_addr[1:0]);

  assign kbd_ready = reset_n && !kbd_full;
  assign kbd_push  = kbd_valid && kbd_ready;
  assign kbd_pop   = rd_en && (reg_off == REG_KBD);

  assign dsp_valid = reset_n && !dsp_empty;
  assign dsp_pop   = dsp_valid && dsp_ready;
  assign dsp_push  = wr_en && (reg_off == REG_DSP);
  // A write into a full FIFO still lands if the display drains a slot that cycle.
  assign dsp_drop  = dsp_push && dsp_full && !dsp_pop;

  assign unused_counts = ^{kbd_count, dsp_count};

  io_fifo #(.WIDTH(7), .DEPTH(KBD_DEPTH)) u_kbd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (kbd_push),
    .wr_data (translate_key(kbd_data, LF_TO_CR != 0, UPCASE != 0)),
    .pop     (kbd_pop),
    .rd_data (kbd_head),
    .full    (kbd_full),
    .empty   (kbd_empty),
    .count   (kbd_count)
  );

  io_fifo #(.WIDTH(7), .DEPTH(DSP_DEPTH)) u_dsp_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (dsp_push),
    .wr_data (cpu_wdata[6:0]),
    .pop     (dsp_pop),
    .rd_data (dsp_data),
    .full    (dsp_full),
    .empty   (dsp_empty),
    .count   (dsp_count)
  );

  // NOTE: every combinational output gets a default first so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    rdata_d = 8'h00;
    if (rd_en) begin
      case (reg_off)
        REG_KBD:   rdata_d = kbd_empty ? {1'b0, last_key_q} : {1'b1, kbd_head};
        REG_KBDCR: rdata_d = {!kbd_empty, 7'b0};
        REG_DSP:   rdata_d = {dsp_full, 7'b0};
        REG_DSPCR: rdata_d = dspcr_q;
        default:   rdata_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q    <= 8'h00;
      last_key_q <= 7'h00;
      dspcr_q    <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      if (kbd_pop && !kbd_empty) last_key_q <= kbd_head;
      if (wr_en && reg_off == REG_DSPCR) dspcr_q <= cpu_wdata;
      if (dsp_drop)
        overflow_q <= 1'b1;
      else if (wr_en && reg_off == REG_DSPCR)
        overflow_q <= 1'b0;
    end
  end

  assign cpu_rdata    = rdata_q;
  assign dsp_overflow = overflow_q;

endmodule
